// File: rtl/traffic_phase_sequencer.sv
// N-approach traffic-light sequencer: green -> yellow -> all-red rotation with demand skipping,
// emergency preemption and a flashing-yellow fault mode, all timed by an external tick strobe.
module traffic_phase_sequencer #(
    parameter int NUM_PHASES   = 4,
    parameter int TW           = 8,
    parameter int GREEN_TICKS  = 5,
    parameter int YELLOW_TICKS = 2,
    parameter int ALLRED_TICKS = 1,
    parameter int SKIP_EN      = 1,
    localparam int PW          = $clog2(NUM_PHASES)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tick_en,
    input  logic [NUM_PHASES-1:0]   req,
    input  logic                    preempt,
    input  logic [PW-1:0]           preempt_phase,
    input  logic                    flash,
    output logic [3*NUM_PHASES-1:0] lights,
    output logic [PW-1:0]           active_phase,
    output logic                    busy_preempt,
    output logic [2:0]              dbg_state
);

    typedef enum logic [2:0] {
        S_GREEN   = 3'd0,
        S_YELLOW  = 3'd1,
        S_ALLRED  = 3'd2,
        S_PREEMPT = 3'd3,
        S_FLASH   = 3'd4
    } state_t;

    localparam logic [TW-1:0] GREEN_LOAD  = TW'(GREEN_TICKS - 1);
    localparam logic [TW-1:0] YELLOW_LOAD = TW'(YELLOW_TICKS - 1);
    localparam logic [TW-1:0] ALLRED_LOAD = TW'(ALLRED_TICKS - 1);
    localparam logic [PW-1:0] LAST_PHASE  = PW'(NUM_PHASES - 1);

    localparam logic [2:0] LAMP_R   = 3'b100;
    localparam logic [2:0] LAMP_Y   = 3'b010;
    localparam logic [2:0] LAMP_G   = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    state_t                  state, state_d;
    logic [TW-1:0]           timer, timer_d;
    logic [PW-1:0]           phase_d;
    logic                    flash_on, flash_on_d;
    logic                    restart, restart_d;
    logic [3*NUM_PHASES-1:0] lights_d;
    logic                    busy_d;
    logic [PW-1:0]           skip_phase;

    // First requesting approach after cur (wrapping, cur itself last); plain successor if none.
    function automatic logic [PW-1:0] pick_next(input logic [PW-1:0] cur,
                                                input logic [NUM_PHASES-1:0] r);
        logic [PW-1:0] sel;
        logic          found;
        int            idx;
        sel   = (cur == LAST_PHASE) ? '0 : cur + 1'b1;
        found = 1'b0;
        if (SKIP_EN != 0) begin
            for (int k = 1; k <= NUM_PHASES; k++) begin
                idx = int'(cur) + k;
                if (idx >= NUM_PHASES) idx = idx - NUM_PHASES;
                if (!found && r[idx]) begin
                    sel   = PW'(idx);
                    found = 1'b1;
                end
            end
        end
        return sel;
    endfunction

    assign skip_phase = pick_next(active_phase, req);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_ALLRED;
            timer        <= ALLRED_LOAD;
            active_phase <= LAST_PHASE;
            lights       <= {NUM_PHASES{LAMP_R}};
            busy_preempt <= 1'b0;
            flash_on     <= 1'b0;
            restart      <= 1'b1;
        end else begin
            state        <= state_d;
            timer        <= timer_d;
            active_phase <= phase_d;
            lights       <= lights_d;
            busy_preempt <= busy_d;
            flash_on     <= flash_on_d;
            restart      <= restart_d;
        end
    end

    // Priority each cycle: flash, then preempt, then the tick-driven timer.
    always_comb begin
        state_d    = state;
        timer_d    = timer;
        phase_d    = active_phase;
        flash_on_d = flash_on;
        restart_d  = restart;

        if (flash) begin
            state_d = S_FLASH;
            if (state != S_FLASH) flash_on_d = 1'b1;
            else if (tick_en)     flash_on_d = ~flash_on;
        end else if (state == S_FLASH) begin
            state_d   = S_ALLRED;
            timer_d   = ALLRED_LOAD;
            restart_d = 1'b1;
        end else begin
            case (state)
                S_GREEN: begin
                    if (preempt) begin
                        if (preempt_phase == active_phase) begin
                            state_d = S_PREEMPT;
                        end else begin
                            state_d = S_YELLOW;
                            timer_d = YELLOW_LOAD;
                        end
                    end else if (tick_en) begin
                        if (timer == '0) begin
                            state_d = S_YELLOW;
                            timer_d = YELLOW_LOAD;
                        end else begin
                            timer_d = timer - 1'b1;
                        end
                    end
                end
                S_YELLOW: begin
                    if (tick_en) begin
                        if (timer == '0) begin
                            state_d = S_ALLRED;
                            timer_d = ALLRED_LOAD;
                        end else begin
                            timer_d = timer - 1'b1;
                        end
                    end
                end
                S_ALLRED: begin
                    if (tick_en) begin
                        if (timer == '0) begin
                            restart_d = 1'b0;
                            if (preempt) begin
                                state_d = S_PREEMPT;
                                phase_d = preempt_phase;
                            end else begin
                                state_d = S_GREEN;
                                timer_d = GREEN_LOAD;
                                phase_d = restart ? '0 : skip_phase;
                            end
                        end else begin
                            timer_d = timer - 1'b1;
                        end
                    end
                end
                S_PREEMPT: begin
                    // Timer is frozen; leave through yellow on release or a retarget.
                    if (!preempt || (preempt_phase != active_phase)) begin
                        state_d = S_YELLOW;
                        timer_d = YELLOW_LOAD;
                    end
                end
                default: begin
                    state_d = S_ALLRED;
                    timer_d = ALLRED_LOAD;
                end
            endcase
        end
    end

    // Lamp pattern is derived from the next state so the registered outputs track the state.
    always_comb begin
        lights_d = {NUM_PHASES{LAMP_R}};
        busy_d   = (state_d == S_PREEMPT);
        for (int i = 0; i < NUM_PHASES; i++) begin
            if (state_d == S_FLASH) begin
                lights_d[3*i +: 3] = flash_on_d ? LAMP_Y : LAMP_OFF;
            end else if (PW'(i) == phase_d) begin
                case (state_d)
                    S_GREEN, S_PREEMPT: lights_d[3*i +: 3] = LAMP_G;
                    S_YELLOW:           lights_d[3*i +: 3] = LAMP_Y;
                    default:            lights_d[3*i +: 3] = LAMP_R;
                endcase
            end
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Self-checking bench for traffic_phase_sequencer: directed sequences plus randomized stimulus,
// every cycle compared against a strobe-counting behavioural model.
module tb_traffic_phase_sequencer;

    localparam int N   = 4;
    localparam int PW  = $clog2(N);
    localparam int GT  = 5;
    localparam int YT  = 2;
    localparam int AT  = 1;
    localparam int SKP = 1;

    localparam int MG = 0, MY = 1, MA = 2, MP = 3, MF = 4;

    logic            clk;
    logic            rst;
    logic            tick_en;
    logic [N-1:0]    req;
    logic            preempt;
    logic [PW-1:0]   preempt_phase;
    logic            flash;
    logic [3*N-1:0]  lights;
    logic [PW-1:0]   active_phase;
    logic            busy_preempt;
    logic [2:0]      dbg_state;

    int checks = 0;
    int errors = 0;

    int m_mode, m_left, m_phase;
    bit m_lit, m_first;
    logic [3*N-1:0] prev_lights;

    traffic_phase_sequencer #(
        .NUM_PHASES(N), .TW(8), .GREEN_TICKS(GT), .YELLOW_TICKS(YT),
        .ALLRED_TICKS(AT), .SKIP_EN(SKP)
    ) dut (
        .clk(clk), .rst(rst), .tick_en(tick_en), .req(req), .preempt(preempt),
        .preempt_phase(preempt_phase), .flash(flash), .lights(lights),
        .active_phase(active_phase), .busy_preempt(busy_preempt), .dbg_state(dbg_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode      = MA;
        m_left      = AT;
        m_phase     = N - 1;
        m_lit       = 1'b0;
        m_first     = 1'b1;
        prev_lights = {N{3'b100}};
    endtask

    function automatic int pick_phase();
        if (SKP != 0)
            for (int k = 1; k <= N; k++)
                if (req[(m_phase + k) % N]) return (m_phase + k) % N;
        return (m_phase + 1) % N;
    endfunction

    // One clock edge of the reference: m_left counts strobes still to be spent in the interval.
    task automatic model_step();
        if (!rst) begin
            model_reset();
        end else if (flash) begin
            if (m_mode != MF) begin
                m_mode = MF;
                m_lit  = 1'b1;
            end else if (tick_en) begin
                m_lit = !m_lit;
            end
        end else if (m_mode == MF) begin
            m_mode  = MA;
            m_left  = AT;
            m_first = 1'b1;
        end else if (m_mode == MP) begin
            if (!preempt || int'(preempt_phase) != m_phase) begin
                m_mode = MY;
                m_left = YT;
            end
        end else if (m_mode == MG && preempt) begin
            if (int'(preempt_phase) == m_phase) m_mode = MP;
            else begin
                m_mode = MY;
                m_left = YT;
            end
        end else if (tick_en) begin
            m_left--;
            if (m_left == 0) begin
                case (m_mode)
                    MG: begin m_mode = MY; m_left = YT; end
                    MY: begin m_mode = MA; m_left = AT; end
                    default: begin
                        if (preempt) begin
                            m_mode  = MP;
                            m_phase = int'(preempt_phase);
                        end else begin
                            m_mode  = MG;
                            m_left  = GT;
                            m_phase = m_first ? 0 : pick_phase();
                        end
                        m_first = 1'b0;
                    end
                endcase
            end
        end
    endtask

    function automatic logic [3*N-1:0] exp_lights();
        logic [3*N-1:0] v;
        for (int i = 0; i < N; i++) begin
            if (m_mode == MF)       v[3*i +: 3] = m_lit ? 3'b010 : 3'b000;
            else if (i != m_phase)  v[3*i +: 3] = 3'b100;
            else if (m_mode == MG || m_mode == MP) v[3*i +: 3] = 3'b001;
            else if (m_mode == MY)  v[3*i +: 3] = 3'b010;
            else                    v[3*i +: 3] = 3'b100;
        end
        return v;
    endfunction

    task automatic compare_outputs();
        int nonred;
        int g2r;
        nonred = 0;
        g2r    = 0;
        check("lights", 32'(lights), 32'(exp_lights()));
        check("active_phase", 32'(active_phase), 32'(m_phase));
        check("busy_preempt", 32'(busy_preempt), 32'(m_mode == MP));
        for (int i = 0; i < N; i++) begin
            if (lights[3*i +: 3] != 3'b100) nonred++;
            if (prev_lights[3*i +: 3] == 3'b001 && lights[3*i +: 3] == 3'b100) g2r++;
        end
        if (m_mode != MF) check("nonred_groups_le1", 32'(nonred <= 1), 32'd1);
        if (rst) check("no_green_to_red", 32'(g2r), 32'd0);
        prev_lights = lights;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            model_step();
            compare_outputs();
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_lights"}, 32'(lights), 32'(12'b100_100_100_100));
        check({tag, "_active"}, 32'(active_phase), 32'(N - 1));
        check({tag, "_busy"}, 32'(busy_preempt), 32'd0);
    endtask

    initial begin
        model_reset();
        rst           = 1'b0;
        tick_en       = 1'($urandom);
        req           = N'($urandom);
        preempt       = 1'($urandom);
        preempt_phase = PW'($urandom);
        flash         = 1'($urandom);
        run(3);
        check_reset_values("reset");

        // Round-robin with every approach demanding.
        rst = 1'b1; tick_en = 1'b1; req = 4'hF; preempt = 1'b0; flash = 1'b0;
        preempt_phase = '0;
        run(1);
        check("rr_p0_green", 32'(lights), 32'(12'b100_100_100_001));
        check("rr_p0_active", 32'(active_phase), 32'd0);
        run(5);
        check("rr_p0_yellow", 32'(lights), 32'(12'b100_100_100_010));
        run(2);
        check("rr_allred", 32'(lights), 32'(12'b100_100_100_100));
        run(1);
        check("rr_p1_green", 32'(lights), 32'(12'b100_100_001_100));
        run(24);
        check("rr_rotation_32", 32'(lights), 32'(12'b100_100_100_001));

        // Demand skipping, then strict order with no demand.
        req = 4'b1001;
        run(8);  check("skip_p3", 32'(active_phase), 32'd3);
        run(8);  check("skip_p0", 32'(active_phase), 32'd0);
        req = 4'b0000;
        run(8);  check("strict_p1", 32'(active_phase), 32'd1);
        run(8);  check("strict_p2", 32'(active_phase), 32'd2);
        run(8);  check("strict_p3", 32'(active_phase), 32'd3);
        run(8);  check("strict_p0", 32'(active_phase), 32'd0);
        run(8);  check("strict_p1b", 32'(lights), 32'(12'b100_100_001_100));

        // Preemption of phase 3 during phase 1 green.
        run(1);
        preempt = 1'b1; preempt_phase = 2'd3;
        run(1);  check("pre_yellow", 32'(lights), 32'(12'b100_100_010_100));
        run(2);  check("pre_allred", 32'(lights), 32'(12'b100_100_100_100));
        run(1);  check("pre_green3", 32'(lights), 32'(12'b001_100_100_100));
        check("pre_busy", 32'(busy_preempt), 32'd1);
        run(50); check("pre_hold", 32'(lights), 32'(12'b001_100_100_100));
        check("pre_hold_busy", 32'(busy_preempt), 32'd1);
        preempt = 1'b0;
        run(1);  check("pre_rel_yellow", 32'(lights), 32'(12'b010_100_100_100));
        check("pre_rel_busy", 32'(busy_preempt), 32'd0);
        run(2);  check("pre_rel_allred", 32'(lights), 32'(12'b100_100_100_100));
        run(1);  check("pre_rel_p0", 32'(lights), 32'(12'b100_100_100_001));

        // Flash entered mid-yellow.
        run(5);  check("fl_pre_yellow", 32'(lights), 32'(12'b100_100_100_010));
        flash = 1'b1;
        run(1);  check("fl_lit", 32'(lights), 32'(12'b010_010_010_010));
        run(1);  check("fl_dark", 32'(lights), 32'(12'b000_000_000_000));
        run(1);  check("fl_lit2", 32'(lights), 32'(12'b010_010_010_010));
        tick_en = 1'b0;
        run(3);  check("fl_no_tick", 32'(lights), 32'(12'b010_010_010_010));
        tick_en = 1'b1; flash = 1'b0;
        run(1);  check("fl_exit_allred", 32'(lights), 32'(12'b100_100_100_100));
        run(1);  check("fl_exit_p0", 32'(lights), 32'(12'b100_100_100_001));

        // Asynchronous reset pulse away from any clock edge.
        run(2);
        #3 rst = 1'b0;
        #1 check_reset_values("async_reset");
        model_reset();
        #2 rst = 1'b1;
        run(1);  check("restart_p0", 32'(lights), 32'(12'b100_100_100_001));
        run(8);  check("restart_p1", 32'(lights), 32'(12'b100_100_001_100));

        // Randomized stimulus against the model.
        for (int c = 0; c < 3000; c++) begin
            tick_en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) req = N'($urandom);
            if ($urandom_range(0, 40) == 0) preempt = !preempt;
            if ($urandom_range(0, 30) == 0) preempt_phase = PW'($urandom_range(0, N - 1));
            if (!flash && $urandom_range(0, 200) == 0) flash = 1'b1;
            else if (flash && $urandom_range(0, 20) == 0) flash = 1'b0;
            rst = ($urandom_range(0, 500) != 0);
            run(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
